// File: rtl/cmd_frame_receiver_if.sv
// Byte-stream input and command/acknowledge outputs of cmd_frame_receiver.
// master = byte source plus command consumer, slave = the receiver.
interface cmd_frame_receiver_if;
    logic       rx_byte_valid;
    logic [7:0] rx_byte;
    logic       rx_sof;
    logic       rx_eof;
    logic [1:0] cmd_out;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       ack_valid;
    logic [1:0] ack_code;

    // cmd_out transfers on a sys_clk edge where cmd_valid && cmd_ready; once raised,
    // cmd_valid stays high and cmd_out stays stable until that transfer happens.
    modport master (
        output rx_byte_valid, rx_byte, rx_sof, rx_eof, cmd_ready,
        input  cmd_out, cmd_valid, ack_valid, ack_code
    );
    modport slave (
        input  rx_byte_valid, rx_byte, rx_sof, rx_eof, cmd_ready,
        output cmd_out, cmd_valid, ack_valid, ack_code
    );
endinterface

// File: rtl/cmd_frame_receiver.sv
// Parses 3-byte command frames (header, command, checksum) into a 1-entry valid/ready register.
// Define CMD_RX_ACK_EN to build the one-cycle ack_valid/ack_code strobe; otherwise both are tied to 0.
module cmd_frame_receiver #(
    parameter logic [7:0]  HDR_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    cmd_frame_receiver_if.slave  bus,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [1:0]           dbg_state
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_SUM  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [1:0]        cmd_lat_q, cmd_lat_d;
    logic [1:0]        cmd_out_q, cmd_out_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    state_t idle_next;
    logic   idle_err;
    logic   frame_err;
    logic   frame_good;
    logic   timeout;
    logic   load;
    logic   overrun;

    // How a start-of-frame byte is handled, shared by idle, restart and drop recovery.
    always_comb begin
        idle_next = S_IDLE;
        idle_err  = 1'b0;
        if (bus.rx_sof) begin
            if (bus.rx_byte == HDR_BYTE) begin
                if (bus.rx_eof) begin
                    idle_err = 1'b1;
                end else begin
                    idle_next = S_CMD;
                end
            end else begin
                idle_err  = 1'b1;
                idle_next = bus.rx_eof ? S_IDLE : S_DROP;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_lat_d  = cmd_lat_q;
        tmo_d      = '0;
        frame_err  = 1'b0;
        frame_good = 1'b0;
        timeout    = 1'b0;
        if (bus.rx_byte_valid) begin
            case (state_q)
                S_IDLE: begin
                    state_d   = idle_next;
                    frame_err = idle_err;
                end
                S_CMD: begin
                    frame_err = 1'b1;
                    if (bus.rx_sof) begin
                        state_d = idle_next;
                    end else if (bus.rx_eof) begin
                        state_d = S_IDLE;
                    end else if (bus.rx_byte[7:2] != 6'd0) begin
                        state_d = S_DROP;
                    end else begin
                        frame_err = 1'b0;
                        cmd_lat_d = bus.rx_byte[1:0];
                        state_d   = S_SUM;
                    end
                end
                S_SUM: begin
                    frame_err = 1'b1;
                    if (bus.rx_sof) begin
                        state_d = idle_next;
                    end else if (bus.rx_byte == (HDR_BYTE ^ {6'd0, cmd_lat_q}) && bus.rx_eof) begin
                        frame_err  = 1'b0;
                        frame_good = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = bus.rx_eof ? S_IDLE : S_DROP;
                    end
                end
                S_DROP: begin
                    // The dropped frame was already counted, so a restart adds only its own error.
                    if (bus.rx_sof) begin
                        state_d   = idle_next;
                        frame_err = idle_err;
                    end else if (bus.rx_eof) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q == S_CMD || state_q == S_SUM) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                timeout = 1'b1;
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // A completing frame may reuse the register in the same cycle the consumer drains it.
    always_comb begin
        load        = frame_good && (!cmd_valid_q || bus.cmd_ready);
        overrun     = frame_good && !load;
        cmd_out_d   = cmd_out_q;
        cmd_valid_d = cmd_valid_q;
        if (load) begin
            cmd_out_d   = cmd_lat_q;
            cmd_valid_d = 1'b1;
        end else if (cmd_valid_q && bus.cmd_ready) begin
            cmd_valid_d = 1'b0;
        end
        err_cnt_d = err_cnt_q;
        if ((frame_err || timeout || overrun) && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            cmd_lat_q   <= 2'b00;
            cmd_out_q   <= 2'b00;
            cmd_valid_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            cmd_lat_q   <= cmd_lat_d;
            cmd_out_q   <= cmd_out_d;
            cmd_valid_q <= cmd_valid_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

`ifdef CMD_RX_ACK_EN
    logic       ack_valid_q, ack_valid_d;
    logic [1:0] ack_code_q, ack_code_d;

    always_comb begin
        ack_valid_d = load;
        ack_code_d  = load ? cmd_lat_q : 2'b00;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_valid_q <= 1'b0;
            ack_code_q  <= 2'b00;
        end else begin
            ack_valid_q <= ack_valid_d;
            ack_code_q  <= ack_code_d;
        end
    end

    assign bus.ack_valid = ack_valid_q;
    assign bus.ack_code  = ack_code_q;
`else
    assign bus.ack_valid = 1'b0;
    assign bus.ack_code  = 2'b00;
`endif

    assign bus.cmd_out   = cmd_out_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign err_cnt       = err_cnt_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_cmd_frame_receiver.sv
// Randomized frame-level bench for cmd_frame_receiver: frames are classified as good or bad by
// the framing rules, good commands go to an expected queue checked at every handshake.
module tb_cmd_frame_receiver;
    localparam logic [7:0] HDR = 8'hA5;
    localparam int         TMO = 1024;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] err_cnt;
    logic [1:0] dbg_state;

    cmd_frame_receiver_if bus();

    cmd_frame_receiver #(
        .HDR_BYTE   (HDR),
        .TIMEOUT_CYC(TMO),
        .CNT_W      (8)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .err_cnt  (err_cnt),
        .dbg_state(dbg_state)
    );

    always #10 sys_clk = ~sys_clk;

    int         checks = 0;
    int         errors = 0;
    int         exp_err = 0;
    logic [1:0] exp_q[$];
    bit         model_occ = 1'b0;
    bit         exp_ack = 1'b0;
    logic [1:0] exp_ack_code = 2'b00;
    bit         good_flag = 1'b0;
    logic [1:0] good_cmd = 2'b00;
    bit         rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add_err();
        if (exp_err < 255) exp_err++;
    endfunction

    // Inputs change 1 time unit after posedge; everything is sampled at negedge.
    task automatic drive(input logic [7:0] b, input logic sof, input logic eof,
                         input logic good, input logic [1:0] c);
        @(posedge sys_clk); #1;
        bus.rx_byte_valid = 1'b1;
        bus.rx_byte       = b;
        bus.rx_sof        = sof;
        bus.rx_eof        = eof;
        good_flag         = good;
        good_cmd          = c;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk); #1;
            bus.rx_byte_valid = 1'b0;
            bus.rx_sof        = 1'b0;
            bus.rx_eof        = 1'b0;
            bus.rx_byte       = 8'h00;
            good_flag         = 1'b0;
        end
    endtask

    task automatic gap();
        idle($urandom_range(0, 3));
    endtask

    task automatic send_good(input logic [1:0] c);
        drive(HDR, 1'b1, 1'b0, 1'b0, 2'd0);
        gap();
        drive({6'd0, c}, 1'b0, 1'b0, 1'b0, 2'd0);
        gap();
        drive(HDR ^ {6'd0, c}, 1'b0, 1'b1, 1'b1, c);
        idle(1);
    endtask

    task automatic send_bad_sum(input logic [1:0] c);
        logic [7:0] x;
        x = 8'($urandom_range(1, 255));
        drive(HDR, 1'b1, 1'b0, 1'b0, 2'd0);
        gap();
        drive({6'd0, c}, 1'b0, 1'b0, 1'b0, 2'd0);
        gap();
        drive(HDR ^ {6'd0, c} ^ x, 1'b0, 1'b1, 1'b0, 2'd0);
        idle(1);
        add_err();
    endtask

    task automatic check_err(input string nm);
        idle(3);
        @(negedge sys_clk);
        check(nm, 32'(err_cnt), exp_err);
    endtask

    task automatic send_kind(input int k);
        logic [1:0] c;
        logic [7:0] b;
        int         n;
        c = 2'($urandom_range(0, 3));
        case (k)
            0, 9: send_good(c);
            1: send_bad_sum(c);
            2: begin
                drive(HDR, 1'b1, 1'b0, 1'b0, 2'd0);
                gap();
                drive({6'd0, c}, 1'b0, 1'b1, 1'b0, 2'd0);
                idle(1);
                add_err();
            end
            3: begin
                n = $urandom_range(1, 3);
                drive(HDR, 1'b1, 1'b0, 1'b0, 2'd0);
                drive({6'd0, c}, 1'b0, 1'b0, 1'b0, 2'd0);
                drive(HDR ^ {6'd0, c}, 1'b0, 1'b0, 1'b0, 2'd0);
                for (int i = 1; i <= n; i++) begin
                    gap();
                    drive(8'($urandom_range(0, 255)), 1'b0, (i == n), 1'b0, 2'd0);
                end
                idle(1);
                add_err();
            end
            4: begin
                do b = 8'($urandom_range(0, 255)); while (b == HDR);
                n = $urandom_range(1, 3);
                drive(b, 1'b1, (n == 1), 1'b0, 2'd0);
                for (int i = 2; i <= n; i++) begin
                    gap();
                    drive(8'($urandom_range(0, 255)), 1'b0, (i == n), 1'b0, 2'd0);
                end
                idle(1);
                add_err();
            end
            5: begin
                drive(HDR, 1'b1, 1'b0, 1'b0, 2'd0);
                gap();
                drive(8'($urandom_range(4, 255)), 1'b0, 1'b0, 1'b0, 2'd0);
                gap();
                drive(8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0, 2'd0);
                idle(1);
                add_err();
            end
            6: begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) begin
                    drive(8'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 2'd0);
                end
                idle(1);
            end
            7: begin
                drive(HDR, 1'b1, 1'b1, 1'b0, 2'd0);
                idle(1);
                add_err();
            end
            default: begin
                drive(HDR, 1'b1, 1'b0, 1'b0, 2'd0);
                if ($urandom_range(0, 1) == 1) begin
                    gap();
                    drive({6'd0, c}, 1'b0, 1'b0, 1'b0, 2'd0);
                end
                gap();
                add_err();
                send_good(2'($urandom_range(0, 3)));
            end
        endcase
        idle($urandom_range(0, 4));
    endtask

    always @(posedge sys_clk) begin
        if (rand_ready) begin
            #1;
            bus.cmd_ready = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard: behavioural 1-entry holding register plus expected command queue.
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            model_occ = 1'b0;
            exp_ack   = 1'b0;
            exp_q.delete();
        end else begin
            check("cmd_valid", 32'(bus.cmd_valid), 32'(model_occ));
`ifdef CMD_RX_ACK_EN
            check("ack_valid", 32'(bus.ack_valid), 32'(exp_ack));
            if (exp_ack) check("ack_code", 32'(bus.ack_code), 32'(exp_ack_code));
`else
            check("ack_tied", 32'({bus.ack_valid, bus.ack_code}), 32'd0);
`endif
            exp_ack = 1'b0;
            if (bus.cmd_valid && bus.cmd_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_unexpected: got %0h expected none at %0t", bus.cmd_out, $time);
                end else begin
                    checks--;
                    check("cmd_out", 32'(bus.cmd_out), 32'(exp_q.pop_front()));
                end
            end
            if (good_flag) begin
                if (!model_occ || bus.cmd_ready) begin
                    exp_q.push_back(good_cmd);
                    model_occ    = 1'b1;
                    exp_ack      = 1'b1;
                    exp_ack_code = good_cmd;
                end else begin
                    add_err();
                end
            end else if (model_occ && bus.cmd_ready) begin
                model_occ = 1'b0;
            end
        end
    end

    initial begin
        #2ms;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        bus.rx_byte_valid = 1'b0;
        bus.rx_byte       = 8'h00;
        bus.rx_sof        = 1'b0;
        bus.rx_eof        = 1'b0;
        bus.cmd_ready     = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_cmd_out", 32'(bus.cmd_out), 32'd0);
        check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_ack", 32'({bus.ack_valid, bus.ack_code}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        idle(2);

        send_good(2'd1);
        check_err("err_after_good");

        drive(HDR, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(8'h02, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(8'hA4, 1'b0, 1'b1, 1'b0, 2'd0);
        idle(1);
        add_err();
        send_good(2'd2);
        check_err("err_bad_sum");

        send_kind(2);
        send_kind(3);
        check_err("err_trunc_long");
        check("state_idle_after_long", 32'(dbg_state), 32'd0);

        // Longest legal byte spacing, then one cycle more.
        drive(HDR, 1'b1, 1'b0, 1'b0, 2'd0);
        idle(TMO - 1);
        drive(8'h01, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(8'hA4, 1'b0, 1'b1, 1'b1, 2'd1);
        idle(1);
        check_err("err_no_timeout");
        drive(HDR, 1'b1, 1'b0, 1'b0, 2'd0);
        idle(TMO);
        add_err();
        drive(8'h03, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(8'hA6, 1'b0, 1'b1, 1'b0, 2'd0);
        idle(1);
        check_err("err_timeout");
        check("state_idle_after_timeout", 32'(dbg_state), 32'd0);

        bus.cmd_ready = 1'b0;
        send_good(2'd1);
        send_good(2'd2);
        check_err("err_overrun");
        check("held_cmd", 32'(bus.cmd_out), 32'd1);
        drive(HDR, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(8'h03, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(8'hA6, 1'b0, 1'b1, 1'b1, 2'd3);
        bus.cmd_ready = 1'b1;
        idle(1);
        @(negedge sys_clk);
        check("no_bubble_valid", 32'(bus.cmd_valid), 32'd1);
        check("no_bubble_cmd", 32'(bus.cmd_out), 32'd3);
        check_err("err_after_no_bubble");

        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) send_kind($urandom_range(0, 9));
        rand_ready = 1'b0;
        idle(2);
        bus.cmd_ready = 1'b1;
        idle(4);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check_err("err_random");

        for (int i = 0; i < 300; i++) send_bad_sum(2'($urandom_range(0, 3)));
        check_err("err_saturate_model");
        check("err_saturated", 32'(err_cnt), 32'hFF);

        drive(HDR, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(8'h01, 1'b0, 1'b0, 1'b0, 2'd0);
        @(posedge sys_clk); #1;
        rst_n             = 1'b0;
        bus.rx_byte_valid = 1'b0;
        good_flag         = 1'b0;
        exp_err           = 0;
        @(negedge sys_clk);
        check("mid_rst_cmd_out", 32'(bus.cmd_out), 32'd0);
        check("mid_rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_ack", 32'({bus.ack_valid, bus.ack_code}), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        drive(8'hA4, 1'b0, 1'b1, 1'b0, 2'd0);
        idle(1);
        check_err("err_partial_discarded");
        send_good(2'd3);
        idle(3);
        check("final_drain", 32'(exp_q.size()), 32'd0);
        check_err("err_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
